// File: rtl/mmio_led_ctrl_if.sv
// -----------------------------------------------------------------------------
// mmio_led_ctrl_if
//   Data-memory bus bundle as seen by the LED/GPIO controller.
//   The CPU side (master) drives the address, write data and the one-cycle
//   read/write strobes. The peripheral side (slave) returns registered read
//   data together with a one-cycle valid pulse.
//
//   Signals:
//     m_addr  [31:0]  byte address              (master -> slave)
//     m_data  [31:0]  write data                (master -> slave)
//     wea             write strobe, one cycle   (master -> slave)
//     rea             read strobe, one cycle    (master -> slave)
//     m_rdata [31:0]  read data, registered     (slave -> master)
//     rvalid          read data valid pulse     (slave -> master)
// -----------------------------------------------------------------------------
interface mmio_led_ctrl_if;
  logic [31:0] m_addr;
  logic [31:0] m_data;
  logic        wea;
  logic        rea;
  logic [31:0] m_rdata;
  logic        rvalid;

  modport master (
    output m_addr,
    output m_data,
    output wea,
    output rea,
    input  m_rdata,
    input  rvalid
  );

  modport slave (
    input  m_addr,
    input  m_data,
    input  wea,
    input  rea,
    output m_rdata,
    output rvalid
  );
endinterface

// File: rtl/mmio_led_ctrl.sv
// -----------------------------------------------------------------------------
// mmio_led_ctrl
//   Memory-mapped controller for N LED/GPIO output channels.
//
//   Each channel has a configuration word at BASE + 4*i:
//     [0]    level
//     [2:1]  mode  (00 static, 01 blink, 10 pwm, 11 treated as static)
//     [15:8] duty  (pwm compare value)
//   A shared prescaler register at BASE + 0x80 holds a 16-bit divisor.
//   The divisor paces an 8-bit timebase counter, and that counter drives
//   both the blink and the pwm modes.
//
//   Ports:
//     clk   system clock, every flop on its rising edge
//     rst   synchronous, active-high reset
//     bus   data-memory bus (slave modport of mmio_led_ctrl_if)
//     led   registered channel outputs, N bits
//
//   Reads are answered one cycle after the strobe. When a read and a write
//   hit the same register on the same edge, the read returns the old value.
// -----------------------------------------------------------------------------
module mmio_led_ctrl #(
  parameter int unsigned N         = 8,
  parameter logic [31:0] BASE      = 32'h0000_3000,
  parameter logic [15:0] PRESC_RST = 16'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  mmio_led_ctrl_if.slave        bus,
  output logic [N-1:0]          led
);

  // Bits of a channel word that exist; everything else reads back as zero.
  localparam logic [31:0] CH_MASK   = 32'h0000_FF07;
  localparam logic [31:0] PRESC_OFF = 32'h0000_0080;
  localparam logic [31:0] CH_SPAN   = 4 * N;

  // Output value of one channel, given its config word and the timebase count.
  function automatic logic chan_out(input logic [31:0] cfg, input logic [7:0] cnt);
    logic v;
    case (cfg[2:1])
      2'b01:   v = cfg[0] & cnt[7];
      2'b10:   v = cfg[0] & (cnt < cfg[15:8]);
      default: v = cfg[0];
    endcase
    return v;
  endfunction

  // Address decode
  logic [31:0] offset_s;
  logic        aligned_s;
  logic        ch_hit_s;
  logic        presc_hit_s;
  logic [N-1:0] ch_sel_s;

  // Register state and next state
  logic [31:0] ch_q [N];
  logic [31:0] ch_d [N];
  logic [15:0] presc_q;
  logic [15:0] presc_d;
  logic        presc_wr_s;

  // Timebase
  logic [15:0] pcnt_q;
  logic [15:0] pcnt_d;
  logic [7:0]  pwm_cnt_q;
  logic [7:0]  pwm_cnt_d;
  logic        tick_s;

  // Outputs
  logic [N-1:0] led_q;
  logic [N-1:0] led_d;
  logic [31:0]  rd_word_s;
  logic [31:0]  rdata_q;
  logic [31:0]  rdata_d;
  logic         rvalid_q;
  logic         rvalid_d;

  // Decode the bus address into a channel select or a prescaler hit.
  // The subtraction wraps for addresses below BASE, so one unsigned compare
  // rejects addresses on both sides of the channel window.
  always_comb begin
    offset_s    = bus.m_addr - BASE;
    aligned_s   = (bus.m_addr[1:0] == 2'b00);
    ch_hit_s    = aligned_s && (offset_s < CH_SPAN);
    presc_hit_s = aligned_s && (offset_s == PRESC_OFF);
    for (int i = 0; i < N; i++) begin
      ch_sel_s[i] = ch_hit_s && (offset_s[6:2] == 5'(i));
    end
  end

  // Select the currently stored word of whichever register is addressed.
  always_comb begin
    rd_word_s = 32'h0000_0000;
    for (int i = 0; i < N; i++) begin
      rd_word_s = rd_word_s | (ch_sel_s[i] ? ch_q[i] : 32'h0000_0000);
    end
    rd_word_s = rd_word_s | (presc_hit_s ? {16'h0000, presc_q} : 32'h0000_0000);
  end

  // Compute the next register contents from bus writes.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      ch_d[i] = (bus.wea && ch_sel_s[i]) ? (bus.m_data & CH_MASK) : ch_q[i];
    end
    presc_wr_s = bus.wea && presc_hit_s;
    presc_d    = presc_wr_s ? bus.m_data[15:0] : presc_q;
  end

  // Prescaler and pwm counter. Writing the divisor restarts both counters,
  // so a new divisor always begins from a clean phase.
  always_comb begin
    tick_s = (pcnt_q == presc_q);
    if (presc_wr_s) begin
      pcnt_d    = 16'd0;
      pwm_cnt_d = 8'd0;
    end else if (tick_s) begin
      pcnt_d    = 16'd0;
      pwm_cnt_d = pwm_cnt_q + 8'd1;
    end else begin
      pcnt_d    = pcnt_q + 16'd1;
      pwm_cnt_d = pwm_cnt_q;
    end
  end

  // Next channel outputs and the registered read response.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      led_d[i] = chan_out(ch_q[i], pwm_cnt_q);
    end
    rvalid_d = bus.rea && (ch_hit_s || presc_hit_s);
    rdata_d  = rvalid_d ? rd_word_s : 32'h0000_0000;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        ch_q[i] <= 32'h0000_0000;
      end
      presc_q   <= PRESC_RST;
      pcnt_q    <= 16'd0;
      pwm_cnt_q <= 8'd0;
      led_q     <= '0;
      rdata_q   <= 32'h0000_0000;
      rvalid_q  <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        ch_q[i] <= ch_d[i];
      end
      presc_q   <= presc_d;
      pcnt_q    <= pcnt_d;
      pwm_cnt_q <= pwm_cnt_d;
      led_q     <= led_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign led         = led_q;
  assign bus.m_rdata = rdata_q;
  assign bus.rvalid  = rvalid_q;

endmodule

// File: tb/tb_mmio_led_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mmio_led_ctrl
//   Bench for mmio_led_ctrl with the default parameters (N=8, BASE=0x3000).
//   A behavioural model tracks the register contents and the number of edges
//   since the timebase was last cleared. It derives the pwm count from that
//   edge count arithmetically, and its expectations are compared against the
//   DUT on every falling edge. Directed checks with hand-computed values
//   anchor the model.
// -----------------------------------------------------------------------------
module tb_mmio_led_ctrl;
  localparam int          N        = 8;
  localparam logic [31:0] BASE     = 32'h0000_3000;
  localparam int          PRESC_ID = 100;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] led;

  mmio_led_ctrl_if bus ();

  mmio_led_ctrl #(.N(N), .BASE(BASE), .PRESC_RST(16'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .led (led)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- model ----------------
  int           m_level [N];
  int           m_mode  [N];
  int           m_duty  [N];
  int           m_presc;
  int           m_k;          // edges since the timebase was last cleared
  bit           m_valid = 1'b0;
  logic [N-1:0] exp_led;
  logic         exp_rvalid;
  logic [31:0]  exp_rdata;

  function automatic int decode(input logic [31:0] a);
    if (a[1:0] != 2'b00) return -1;
    if (a == BASE + 32'h80) return PRESC_ID;
    if (a >= BASE && a < BASE + 32'(4 * N)) return int'((a - BASE) >> 2);
    return -1;
  endfunction

  function automatic logic [31:0] reg_word(input int id);
    if (id == PRESC_ID) return 32'(m_presc) & 32'h0000_FFFF;
    return 32'(m_duty[id] * 256 + m_mode[id] * 2 + m_level[id]);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    int id;
    int pw;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_level[i] = 0; m_mode[i] = 0; m_duty[i] = 0;
      end
      m_presc    = 0;
      m_k        = 0;
      exp_led    = '0;
      exp_rvalid = 1'b0;
      exp_rdata  = 32'h0;
      m_valid    = 1'b1;
    end else begin
      pw = (m_k / (m_presc + 1)) % 256;
      for (int i = 0; i < N; i++) begin
        case (m_mode[i])
          1:       exp_led[i] = (m_level[i] == 1) && (pw >= 128);
          2:       exp_led[i] = (m_level[i] == 1) && (pw < m_duty[i]);
          default: exp_led[i] = (m_level[i] == 1);
        endcase
      end
      id = decode(bus.m_addr);
      if (bus.rea && id >= 0) begin
        exp_rvalid = 1'b1;
        exp_rdata  = reg_word(id);
      end else begin
        exp_rvalid = 1'b0;
        exp_rdata  = 32'h0;
      end
      if (bus.wea && id == PRESC_ID) begin
        m_presc = int'(bus.m_data[15:0]);
        m_k     = 0;
      end else begin
        m_k++;
        if (bus.wea && id >= 0) begin
          m_level[id] = int'(bus.m_data[0]);
          m_mode[id]  = int'(bus.m_data[2:1]);
          m_duty[id]  = int'(bus.m_data[15:8]);
        end
      end
    end
  end

  // Compare the DUT against the model on every cycle once reset has been seen.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_led", 32'(led), 32'(exp_led));
      check("model_rvalid", 32'(bus.rvalid), 32'(exp_rvalid));
      check("model_rdata", bus.m_rdata, exp_rdata);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.m_addr = a; bus.m_data = d; bus.wea = 1'b1;
    @(negedge clk);
    bus.wea = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    bus.m_addr = a; bus.rea = 1'b1;
    @(negedge clk);
    bus.rea = 1'b0;
  endtask

  task automatic rdwr(input logic [31:0] a, input logic [31:0] d);
    bus.m_addr = a; bus.m_data = d; bus.wea = 1'b1; bus.rea = 1'b1;
    @(negedge clk);
    bus.wea = 1'b0; bus.rea = 1'b0;
  endtask

  task automatic count_high(input int b, input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (led[b] === 1'b1) cnt++;
    end
  endtask

  task automatic wait_level(input int b, input logic v, input int budget, output int n);
    n = 0;
    while (led[b] !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int c;
    int n;
    bus.m_addr = 32'h0; bus.m_data = 32'h0; bus.wea = 1'b0; bus.rea = 1'b0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;

    // Reset state and a prescaler read
    check("rst_led", 32'(led), 32'h0);
    check("rst_rvalid", 32'(bus.rvalid), 32'h0);
    check("rst_rdata", bus.m_rdata, 32'h0);
    rd(32'h0000_3080);
    check("presc_rd_valid", 32'(bus.rvalid), 32'h1);
    check("presc_rd_data", bus.m_rdata, 32'h0);
    idle(1);
    check("rvalid_pulse", 32'(bus.rvalid), 32'h0);

    // Static channels
    wr(32'h0000_3000, 32'h1);
    wr(32'h0000_301C, 32'h1);
    idle(1);
    check("led_81", 32'(led), 32'h81);
    wr(32'h0000_3000, 32'h0);
    idle(1);
    check("led_80", 32'(led), 32'h80);

    // Misaligned and unmapped accesses
    wr(32'h0000_3001, 32'h3);
    wr(32'h0000_3020, 32'h3);
    idle(1);
    check("miss_led", 32'(led), 32'h80);
    rd(32'h0000_3020);
    check("miss_rvalid", 32'(bus.rvalid), 32'h0);
    rd(32'h0000_301C);
    check("ch7_rd", bus.m_rdata, 32'h1);

    // Write masking, reserved mode acts as static
    wr(32'h0000_300C, 32'hFFFF_FFFF);
    rd(32'h0000_300C);
    check("ch3_mask", bus.m_rdata, 32'h0000_FF07);
    check("ch3_reserved_led", 32'(led), 32'h88);
    wr(32'h0000_300C, 32'h0);
    wr(32'h0000_3080, 32'hFFFF_0002);
    rd(32'h0000_3080);
    check("presc_mask", bus.m_rdata, 32'h2);

    // PWM duty at a few values, PRESC=0
    wr(32'h0000_3080, 32'h0);
    wr(32'h0000_3008, 32'h0000_4005);
    idle(1);
    count_high(2, 256, c);
    check("pwm_duty40", 32'(c), 32'd64);
    wr(32'h0000_3008, 32'h0000_0005);
    idle(1);
    count_high(2, 256, c);
    check("pwm_duty00", 32'(c), 32'd0);
    wr(32'h0000_3008, 32'h0000_FF05);
    idle(1);
    count_high(2, 256, c);
    check("pwm_dutyFF", 32'(c), 32'd255);

    // Blink with PRESC=3: 512 cycles per half period
    wr(32'h0000_3008, 32'h0);
    wr(32'h0000_3004, 32'h3);
    wr(32'h0000_3080, 32'h3);
    wait_level(1, 1'b1, 2000, n);
    check("blink_rise", 32'(n), 32'd513);
    wait_level(1, 1'b0, 2000, n);
    check("blink_high", 32'(n), 32'd512);
    idle(200);
    wr(32'h0000_3080, 32'h3);
    wait_level(1, 1'b1, 2000, n);
    check("blink_restart", 32'(n), 32'd513);

    // Same-edge read and write returns the old value
    rdwr(32'h0000_3000, 32'h5);
    check("rw_rvalid", 32'(bus.rvalid), 32'h1);
    check("rw_old", bus.m_rdata, 32'h0);
    rd(32'h0000_3000);
    check("rw_new", bus.m_rdata, 32'h5);

    // Reset while pwm is running
    wr(32'h0000_3004, 32'h0);
    wr(32'h0000_3008, 32'h0000_8005);
    wr(32'h0000_3080, 32'h0);
    idle(10);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("rst2_led", 32'(led), 32'h0);
    check("rst2_rvalid", 32'(bus.rvalid), 32'h0);
    rd(32'h0000_3080);
    check("rst2_presc", bus.m_rdata, 32'h0);
    rd(32'h0000_3008);
    check("rst2_ch2", bus.m_rdata, 32'h0);
    rd(32'h0000_301C);
    check("rst2_ch7", bus.m_rdata, 32'h0);
    // duty 1: high only while the pwm count is 0, so the counters must restart cleanly
    wr(32'h0000_3008, 32'h0000_0105);
    idle(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mmio_led_ctrl.md
Name: mmio_led_ctrl

Overview:
Parametrised memory-mapped LED/GPIO output controller on the tinyrv32 data-memory bus (m_addr/m_data/wea). It generalises the fixed 8-LED board mapping to N channels at a configurable base address. Each channel can be driven statically, as a blink or as 8-bit PWM from a shared prescaled timebase. All registers read back with a registered one-cycle latency.

Parameters:
N, 8, number of LED channels (1..32)
BASE, 32'h0000_3000, word-aligned base address of the register window
PRESC_RST, 16'd0, reset value of the prescaler register

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  reset, synchronous, active-high
m_addr  in  32  bus byte address
m_data  in  32  bus write data
wea  in  1  write enable, one-cycle strobe
rea  in  1  read enable, one-cycle strobe
m_rdata  out  32  read data, registered
rvalid  out  1  read data valid, one-cycle pulse
led  out  N  registered LED outputs

Behaviour:
- One clock (clk). Reset rst is synchronous and active-high: on any edge with rst=1 all state is set as below, regardless of wea/rea. Reset mid-operation is abandoned cleanly: there is no pending read, and the counters restart.
- Register map (exact word-address match, m_addr[1:0] must be 00, otherwise no hit):
  - CH[i] at BASE+4*i, i<N.
    - [0] level
    - [2:1] mode: 00 static, 01 blink, 10 pwm, 11 reserved (acts as static)
    - [15:8] duty
    - other bits read 0
    - Reset value 0.
  - PRESC at BASE+0x80: [15:0] divisor, others read 0. Reset value PRESC_RST.
  - Any other address is a miss: writes are ignored, and a read gives no rvalid.
- Write: on an edge with wea=1 and a hit, the register takes m_data (masked to defined bits).
  - A write to PRESC also clears pcnt and pwm_cnt on the same edge.
- Timebase:
  - pcnt (16b) counts 0..PRESC. tick=1 when pcnt==PRESC. On tick, pcnt wraps to 0.
  - PRESC=0 gives a tick every cycle.
  - pwm_cnt (8b) increments on tick and wraps 255->0.
  - Both counters reset to 0.
- Channel output, next-state of led[i] each edge:
  - static: level
  - blink: level & pwm_cnt[7] (period 256 ticks, 50% duty)
  - pwm: level & (pwm_cnt < duty). duty=0 gives always 0. duty=255 gives high 255 of every 256 ticks.
- led resets to 0.
- Latency: a write captured at edge E is visible on led at edge E+1 for static mode.
- Read:
  - On an edge with rea=1 and a hit: at that edge rvalid<=1 and m_rdata<=register value.
  - Otherwise: rvalid<=0 and m_rdata<=0.
  - Reset values: rvalid 0, m_rdata 0.
- wea and rea on the same address, same edge: the write is applied, and the read returns the pre-write value.
- Back-to-back reads on consecutive cycles are each answered; there is no stall.

Test Plan:
- Reset then idle: led==0, rvalid==0, m_rdata==0. Read PRESC -> rdata 0x0000 one cycle later, rvalid pulse of 1 cycle.
- Write 0x1 to 0x3000 and 0x1 to 0x301C -> led==8'h81 one edge after the write. Write 0x0 to 0x3000 -> led==8'h80.
- Write 0x3 to 0x3001 (misaligned) and to 0x3020 (unmapped) -> led unchanged. Read of 0x3020 -> rvalid stays 0.
- PRESC=0, CH[2]=0x0000_4005 (pwm, duty 0x40, level 1) -> led[2] high exactly 64 of every 256 cycles. duty=0x00 -> never high. duty=0xFF -> high 255/256.
- PRESC=3, CH[1]=0x3 (blink) -> led[1] toggles every 128*4=512 cycles. Rewriting PRESC mid-count restarts the phase from 0.
- Read and write CH[0] on the same edge with 0x5 -> rdata returns the old value. A following read returns 0x5. Assert rst while pwm is active -> next edge led==0, CH/PRESC reset, counters 0.
